// File: rtl/sram_arbiter_if.sv
// Requester, response and SRAM port-B/write-port signals shared by sram_arbiter and its environment.
// The slave modport is the arbiter's view; the master modport is the requesters' and SRAM's view.
interface sram_arbiter_if #(
  parameter int l2_num_words = 12
);
  logic                    req_valid_0;
  logic                    req_valid_1;
  logic                    req_ready_0;
  logic                    req_ready_1;
  logic                    req_write_0;
  logic                    req_write_1;
  logic [l2_num_words-1:0] req_addr_0;
  logic [l2_num_words-1:0] req_addr_1;
  logic [31:0]             req_wdata_0;
  logic [31:0]             req_wdata_1;
  logic [3:0]              req_be_0;
  logic [3:0]              req_be_1;
  logic                    rsp_valid_0;
  logic                    rsp_valid_1;
  logic [31:0]             rsp_rdata_0;
  logic [31:0]             rsp_rdata_1;
  logic                    sram_read_enable;
  logic [l2_num_words-1:0] sram_addr_read;
  logic [31:0]             sram_data_read;
  logic                    sram_write_enable;
  logic [l2_num_words-1:0] sram_addr_write;
  logic [31:0]             sram_data_to_write;

  modport slave (
    input  req_valid_0, req_valid_1, req_write_0, req_write_1,
    input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, req_be_0, req_be_1,
    input  sram_data_read,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
    output sram_read_enable, sram_addr_read, sram_write_enable, sram_addr_write, sram_data_to_write
  );

  modport master (
    output req_valid_0, req_valid_1, req_write_0, req_write_1,
    output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1, req_be_0, req_be_1,
    output sram_data_read,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
    input  sram_read_enable, sram_addr_read, sram_write_enable, sram_addr_write, sram_data_to_write
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for SRAM read port B plus the write port, with read-modify-write for
// byte-enabled writes. Define SRAM_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module sram_arbiter #(
  parameter int l2_num_words = 12
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RSP_READ  = 2'd1,
    RSP_WRITE = 2'd2,
    RMW_MERGE = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    grant_r;
  logic [l2_num_words-1:0] addr_r;
  logic [31:0]             wdata_r;
  logic [3:0]              be_r;

  logic                    grant_s;
  logic                    accept_s;
  logic                    sel_write_s;
  logic [l2_num_words-1:0] sel_addr_s;
  logic [31:0]             sel_wdata_s;
  logic [3:0]              sel_be_s;

  // Per byte: take the new byte where enabled, otherwise keep the stored one.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int n = 0; n < 4; n++) begin
      merged[8*n +: 8] = be[n] ? new_word[8*n +: 8] : old_word[8*n +: 8];
    end
    return merged;
  endfunction

`ifdef SRAM_ARB_RR_EN
  logic last_r;

  // Round-robin winner: on a tie, the requester that did not win last time.
  always_comb begin
    if (bus.req_valid_0 && bus.req_valid_1) begin
      grant_s = ~last_r;
    end else if (bus.req_valid_1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Last-granted pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (accept_s) begin
      last_r <= grant_s;
    end
  end
`else
  // Fixed-priority winner: requester 0 whenever it is valid.
  always_comb begin
    if (bus.req_valid_0) begin
      grant_s = 1'b0;
    end else if (bus.req_valid_1) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end
`endif

  // Payload of the arbitration winner.
  always_comb begin
    if (grant_s) begin
      sel_write_s = bus.req_write_1;
      sel_addr_s  = bus.req_addr_1;
      sel_wdata_s = bus.req_wdata_1;
      sel_be_s    = bus.req_be_1;
    end else begin
      sel_write_s = bus.req_write_0;
      sel_addr_s  = bus.req_addr_0;
      sel_wdata_s = bus.req_wdata_0;
      sel_be_s    = bus.req_be_0;
    end
  end

  // Next state, handshake, response and SRAM drive; everything is held at zero during reset.
  always_comb begin
    state_next_s           = state_r;
    accept_s               = 1'b0;
    bus.req_ready_0        = 1'b0;
    bus.req_ready_1        = 1'b0;
    bus.rsp_valid_0        = 1'b0;
    bus.rsp_valid_1        = 1'b0;
    bus.rsp_rdata_0        = 32'd0;
    bus.rsp_rdata_1        = 32'd0;
    bus.sram_read_enable   = 1'b0;
    bus.sram_addr_read     = {l2_num_words{1'b0}};
    bus.sram_write_enable  = 1'b0;
    bus.sram_addr_write    = {l2_num_words{1'b0}};
    bus.sram_data_to_write = 32'd0;
    if (rst) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid_0 || bus.req_valid_1) begin
            accept_s        = 1'b1;
            bus.req_ready_0 = ~grant_s;
            bus.req_ready_1 = grant_s;
            if (!sel_write_s) begin
              bus.sram_read_enable = 1'b1;
              bus.sram_addr_read   = sel_addr_s;
              state_next_s         = RSP_READ;
            end else if (sel_be_s == 4'b1111) begin
              bus.sram_write_enable  = 1'b1;
              bus.sram_addr_write    = sel_addr_s;
              bus.sram_data_to_write = sel_wdata_s;
              state_next_s           = RSP_WRITE;
            end else if (sel_be_s == 4'b0000) begin
              state_next_s = RSP_WRITE;
            end else begin
              // Partial write: fetch the old word now, merge next cycle.
              bus.sram_read_enable = 1'b1;
              bus.sram_addr_read   = sel_addr_s;
              state_next_s         = RMW_MERGE;
            end
          end else begin
            state_next_s = IDLE;
          end
        end
        RSP_READ: begin
          bus.rsp_valid_0 = ~grant_r;
          bus.rsp_valid_1 = grant_r;
          bus.rsp_rdata_0 = grant_r ? 32'd0 : bus.sram_data_read;
          bus.rsp_rdata_1 = grant_r ? bus.sram_data_read : 32'd0;
          state_next_s    = IDLE;
        end
        RSP_WRITE: begin
          bus.rsp_valid_0 = ~grant_r;
          bus.rsp_valid_1 = grant_r;
          state_next_s    = IDLE;
        end
        RMW_MERGE: begin
          bus.sram_write_enable  = 1'b1;
          bus.sram_addr_write    = addr_r;
          bus.sram_data_to_write = merge_bytes(bus.sram_data_read, wdata_r, be_r);
          bus.rsp_valid_0        = ~grant_r;
          bus.rsp_valid_1        = grant_r;
          state_next_s           = IDLE;
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // State register and latched request payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= 1'b0;
      addr_r  <= {l2_num_words{1'b0}};
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        grant_r <= grant_s;
        addr_r  <= sel_addr_s;
        wdata_r <= sel_wdata_s;
        be_r    <= sel_be_s;
      end
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized single requests,
// checked against a word-array reference model. Honours SRAM_ARB_RR_EN for arbitration checks.
module tb_sram_arbiter;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        last_grant;

  sram_arbiter_if #(.l2_num_words(AW)) bus ();
  sram_arbiter #(.l2_num_words(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // SRAM behaviour: registered read with one-cycle latency, synchronous whole-word write.
  always @(posedge clk) begin
    if (bus.sram_read_enable) bus.sram_data_read <= mem[bus.sram_addr_read];
    if (bus.sram_write_enable) mem[bus.sram_addr_write] <= bus.sram_data_to_write;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                              input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_word & mask) | (old_word & ~mask);
  endfunction

  function automatic int winner();
`ifdef SRAM_ARB_RR_EN
    return (last_grant == 1'b1) ? 0 : 1;
`else
    return 0;
`endif
  endfunction

  function automatic logic ready_of(input int id);
    return (id == 0) ? bus.req_ready_0 : bus.req_ready_1;
  endfunction

  function automatic logic rsp_of(input int id);
    return (id == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1;
  endfunction

  function automatic logic [31:0] rdata_of(input int id);
    return (id == 0) ? bus.rsp_rdata_0 : bus.rsp_rdata_1;
  endfunction

  task automatic drive(input int id, input logic v, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (id == 0) begin
      bus.req_valid_0 = v; bus.req_write_0 = wr; bus.req_addr_0 = a; bus.req_wdata_0 = d; bus.req_be_0 = be;
    end else begin
      bus.req_valid_1 = v; bus.req_write_1 = wr; bus.req_addr_1 = a; bus.req_wdata_1 = d; bus.req_be_1 = be;
    end
  endtask

  // One request from a single requester, checked through accept, response and pulse end.
  task automatic do_req(input int id, input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    logic [31:0] merged;
    logic        partial;
    logic        full;
    partial = wr && (be != 4'h0) && (be != 4'hF);
    full    = wr && (be == 4'hF);
    drive(id, 1'b1, wr, a, d, be);
    #1;
    check("accept_ready", {31'd0, ready_of(id)}, 32'd1);
    check("other_ready", {31'd0, ready_of(1 - id)}, 32'd0);
    check("accept_rd_en", {31'd0, bus.sram_read_enable}, {31'd0, (!wr || partial)});
    check("accept_wr_en", {31'd0, bus.sram_write_enable}, {31'd0, full});
    if (!wr || partial) check("accept_rd_addr", {20'd0, bus.sram_addr_read}, {20'd0, a});
    if (full) begin
      check("accept_wr_addr", {20'd0, bus.sram_addr_write}, {20'd0, a});
      check("accept_wr_data", bus.sram_data_to_write, d);
    end
    merged = model_merge(ref_mem[a], d, be);
    cyc();
    drive(id, 1'b0, wr, a, d, be);
    #1;
    check("rsp_valid", {31'd0, rsp_of(id)}, 32'd1);
    check("rsp_other_valid", {31'd0, rsp_of(1 - id)}, 32'd0);
    check("rsp_rdata", rdata_of(id), wr ? 32'd0 : ref_mem[a]);
    check("rsp_other_rdata", rdata_of(1 - id), 32'd0);
    check("rsp_wr_en", {31'd0, bus.sram_write_enable}, {31'd0, partial});
    check("rsp_rd_en", {31'd0, bus.sram_read_enable}, 32'd0);
    if (partial) begin
      check("rmw_addr", {20'd0, bus.sram_addr_write}, {20'd0, a});
      check("rmw_data", bus.sram_data_to_write, merged);
    end
    if (wr) ref_mem[a] = merged;
    last_grant = (id == 1) ? 1'b1 : 1'b0;
    cyc();
    #1;
    check("rsp_pulse_end", {31'd0, rsp_of(id)}, 32'd0);
  endtask

  initial begin
    logic [11:0] a0;
    logic [11:0] a1;
    logic [11:0] a;
    logic [31:0] exp_data;
    int          w;

    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 12'h005, 32'd0, 4'h0);
    drive(1, 1'b0, 1'b0, 12'h000, 32'd0, 4'h0);
    cyc();
    cyc();
    #1;
    check("reset_ready_0", {31'd0, bus.req_ready_0}, 32'd0);
    check("reset_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
    check("reset_rsp_0", {31'd0, bus.rsp_valid_0}, 32'd0);
    check("reset_rsp_1", {31'd0, bus.rsp_valid_1}, 32'd0);
    check("reset_rdata_0", bus.rsp_rdata_0, 32'd0);
    check("reset_rdata_1", bus.rsp_rdata_1, 32'd0);
    check("reset_rd_en", {31'd0, bus.sram_read_enable}, 32'd0);
    check("reset_wr_en", {31'd0, bus.sram_write_enable}, 32'd0);
    check("reset_rd_addr", {20'd0, bus.sram_addr_read}, 32'd0);
    check("reset_wr_addr", {20'd0, bus.sram_addr_write}, 32'd0);
    check("reset_wr_data", bus.sram_data_to_write, 32'd0);
    drive(0, 1'b0, 1'b0, 12'h000, 32'd0, 4'h0);
    cyc();
    rst = 1'b0;
    last_grant = 1'b1;

    // Directed scenarios: full write/read, RMW merge, zero-enable write.
    do_req(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    do_req(0, 1'b0, 12'h010, 32'd0, 4'h0);
    check("scn_readback_010", ref_mem[12'h010], 32'hDEADBEEF);
    do_req(0, 1'b1, 12'h020, 32'h11223344, 4'hF);
    do_req(1, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101);
    check("scn_merge_020", mem[12'h020], 32'h11BB33DD);
    do_req(1, 1'b0, 12'h020, 32'd0, 4'h0);
    do_req(0, 1'b1, 12'h030, 32'h00000055, 4'hF);
    do_req(1, 1'b1, 12'h030, 32'hFFFFFFFF, 4'h0);
    do_req(0, 1'b0, 12'h030, 32'd0, 4'h0);
    check("scn_be0_030", mem[12'h030], 32'h00000055);

    // Preload a small window, then random traffic within it.
    for (int i = 0; i < 16; i++) begin
      do_req(i % 2, 1'b1, 12'h100 + 12'(i), $urandom, 4'hF);
    end
    for (int i = 0; i < 24; i++) begin
      do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             12'h100 + 12'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    end

    // Both requesters continuously valid for 8 grants.
    a0 = 12'h100 + 12'($urandom_range(0, 15));
    a1 = 12'h100 + 12'($urandom_range(0, 15));
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b1, 1'b0, a0, 32'd0, 4'h0);
      drive(1, 1'b1, 1'b0, a1, 32'd0, 4'h0);
      #1;
      w = winner();
      check("tie_ready_0", {31'd0, bus.req_ready_0}, (w == 0) ? 32'd1 : 32'd0);
      check("tie_ready_1", {31'd0, bus.req_ready_1}, (w == 1) ? 32'd1 : 32'd0);
      exp_data = (w == 1) ? ref_mem[a1] : ref_mem[a0];
      cyc();
      #1;
      check("tie_rsp_valid", {31'd0, rsp_of(w)}, 32'd1);
      check("tie_rsp_other", {31'd0, rsp_of(1 - w)}, 32'd0);
      check("tie_rsp_rdata", rdata_of(w), exp_data);
      check("tie_busy_ready", {30'd0, bus.req_ready_1, bus.req_ready_0}, 32'd0);
      last_grant = (w == 1) ? 1'b1 : 1'b0;
      if (w == 1) a1 = 12'h100 + 12'($urandom_range(0, 15));
      else a0 = 12'h100 + 12'($urandom_range(0, 15));
      cyc();
    end
    drive(0, 1'b0, 1'b0, a0, 32'd0, 4'h0);
    drive(1, 1'b0, 1'b0, a1, 32'd0, 4'h0);

    // Back-to-back reads from requester 0: ready every other cycle, single-cycle responses.
    a = 12'h100 + 12'($urandom_range(0, 15));
    exp_data = 32'd0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1'b1, 1'b0, a, 32'd0, 4'h0);
      #1;
      if (k % 2 == 0) begin
        check("b2b_ready_on", {31'd0, bus.req_ready_0}, 32'd1);
        check("b2b_rsp_off", {31'd0, bus.rsp_valid_0}, 32'd0);
        exp_data = ref_mem[a];
      end else begin
        check("b2b_ready_off", {31'd0, bus.req_ready_0}, 32'd0);
        check("b2b_rsp_on", {31'd0, bus.rsp_valid_0}, 32'd1);
        check("b2b_rdata", bus.rsp_rdata_0, exp_data);
        a = 12'h100 + 12'($urandom_range(0, 15));
      end
      cyc();
    end
    drive(0, 1'b0, 1'b0, a, 32'd0, 4'h0);
    last_grant = 1'b0;
    #1;
    check("b2b_rsp_end", {31'd0, bus.rsp_valid_0}, 32'd0);
    cyc();

    // Reset in the response cycle of a read drops the response.
    a = 12'h100 + 12'($urandom_range(0, 15));
    drive(0, 1'b1, 1'b0, a, 32'd0, 4'h0);
    #1;
    check("rstmid_accept", {31'd0, bus.req_ready_0}, 32'd1);
    cyc();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, a, 32'd0, 4'h0);
    #1;
    check("rstmid_rsp_0", {31'd0, bus.rsp_valid_0}, 32'd0);
    check("rstmid_rsp_1", {31'd0, bus.rsp_valid_1}, 32'd0);
    check("rstmid_rdata_0", bus.rsp_rdata_0, 32'd0);
    cyc();
    rst = 1'b0;
    last_grant = 1'b1;
    #1;
    check("rstmid_no_late_rsp", {31'd0, bus.rsp_valid_0}, 32'd0);
    a0 = 12'h100 + 12'($urandom_range(0, 15));
    a1 = 12'h100 + 12'($urandom_range(0, 15));
    drive(0, 1'b1, 1'b0, a0, 32'd0, 4'h0);
    drive(1, 1'b1, 1'b0, a1, 32'd0, 4'h0);
    #1;
    check("rstmid_first_ready_0", {31'd0, bus.req_ready_0}, 32'd1);
    check("rstmid_first_ready_1", {31'd0, bus.req_ready_1}, 32'd0);
    cyc();
    drive(0, 1'b0, 1'b0, a0, 32'd0, 4'h0);
    drive(1, 1'b0, 1'b0, a1, 32'd0, 4'h0);
    #1;
    check("rstmid_first_rsp", {31'd0, bus.rsp_valid_0}, 32'd1);
    check("rstmid_first_rdata", bus.rsp_rdata_0, ref_mem[a0]);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
